// File: rtl/xillybus_mem8_responder.sv
// Byte-wide 32-entry seekable memory behind a Xillybus-style write stream,
// read stream and seek port. A registered fabric-side read port gives logic
// in the FPGA direct access to the same storage.
//
// Handshake: the write side uses a strobe/backpressure pair. A byte is
// taken on a rising edge where wren=1 and full=0. The read side uses a
// strobe/availability pair. A byte is consumed on a rising edge where
// rden=1 and empty=0, and that byte appears on the data output in the
// following cycle. A seek strobe wins over both strobes in its cycle.
// quiesce also suppresses both sides.
module xillybus_mem8_responder #(
    parameter bit EOF_ON_WRAP = 1'b0
) (
    input  logic       bus_clk,
    input  logic       trn_reset_n,
    input  logic       quiesce,
    input  logic       user_w_mem_8_wren,
    input  logic [7:0] user_w_mem_8_data,
    output logic       user_w_mem_8_full,
    input  logic       user_w_mem_8_open,
    input  logic       user_r_mem_8_rden,
    output logic [7:0] user_r_mem_8_data,
    output logic       user_r_mem_8_empty,
    output logic       user_r_mem_8_eof,
    input  logic       user_r_mem_8_open,
    input  logic [4:0] user_mem_8_addr,
    input  logic       user_mem_8_addr_update,
    input  logic [4:0] fab_addr,
    output logic [7:0] fab_data,
    output logic [1:0] dbg_rd_state,
    output logic [4:0] dbg_wp,
    output logic [4:0] dbg_rp,
    output logic [1:0] dbg_open
);

    // Read-side stream states
    localparam logic [1:0] ST_CLOSED = 2'd0;
    localparam logic [1:0] ST_SEEK   = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [4:0] LAST_ADDR = 5'd31;

    logic [7:0] mem [32];
    logic [4:0] wp;
    logic [4:0] rp;
    logic [1:0] rd_state;
    logic [1:0] rd_state_nxt;
    logic       full_q;
    logic       empty_q;
    logic       eof_q;
    logic [7:0] rd_data_q;
    logic [7:0] fab_data_q;

    logic       wr_fire;
    logic       rd_fire;
    logic       bypass;

    // A seek or a quiesced core blocks both strobes. Writes also obey the
    // registered backpressure, and reads obey the registered availability.
    assign wr_fire = user_w_mem_8_wren && !user_mem_8_addr_update &&
                     !quiesce && !full_q;
    assign rd_fire = user_r_mem_8_rden && !empty_q &&
                     !user_mem_8_addr_update && !quiesce;

    // A read and a write at the same pointer in one cycle return the byte
    // being written, so the host never observes a stale location.
    assign bypass  = wr_fire && (rp == wp);

    // Storage: cleared on reset, written at wp on an accepted write
    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_fire) begin
            mem[wp] <= user_w_mem_8_data;
        end
    end

    // Pointers: a seek loads both pointers, otherwise each advances mod 32
    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            wp <= 5'd0;
            rp <= 5'd0;
        end else if (user_mem_8_addr_update) begin
            wp <= user_mem_8_addr;
            rp <= user_mem_8_addr;
        end else begin
            if (wr_fire) begin
                wp <= wp + 5'd1;
            end
            if (rd_fire) begin
                rp <= rp + 5'd1;
            end
        end
    end

    // Read data register: updated only by an accepted read, held otherwise
    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            rd_data_q <= 8'h00;
        end else if (rd_fire) begin
            rd_data_q <= bypass ? user_w_mem_8_data : mem[rp];
        end
    end

    // Fabric port: plain registered lookup, returns the pre-write value
    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            fab_data_q <= 8'h00;
        end else begin
            fab_data_q <= mem[fab_addr];
        end
    end

    // Write backpressure: asserted in reset and one cycle after quiesce
    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            full_q <= 1'b1;
        end else begin
            full_q <= quiesce;
        end
    end

    // Read-stream next state. Closing or quiescing wins, then seeking.
    always_comb begin
        rd_state_nxt = rd_state;
        if (!user_r_mem_8_open || quiesce) begin
            rd_state_nxt = ST_CLOSED;
        end else if (user_mem_8_addr_update) begin
            rd_state_nxt = ST_SEEK;
        end else begin
            case (rd_state)
                ST_CLOSED: rd_state_nxt = ST_READY;
                ST_SEEK:   rd_state_nxt = ST_READY;
                ST_READY: begin
                    if (EOF_ON_WRAP && rd_fire && (rp == LAST_ADDR)) begin
                        rd_state_nxt = ST_DONE;
                    end
                end
                ST_DONE:   rd_state_nxt = ST_DONE;
                default:   rd_state_nxt = ST_CLOSED;
            endcase
        end
    end

    // State register. The empty and eof flags are decoded from the next
    // state, so they stay aligned with the state they describe.
    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            rd_state <= ST_CLOSED;
            empty_q  <= 1'b1;
            eof_q    <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            empty_q  <= (rd_state_nxt != ST_READY);
            eof_q    <= (rd_state_nxt == ST_DONE);
        end
    end

    assign user_w_mem_8_full  = full_q;
    assign user_r_mem_8_data  = rd_data_q;
    assign user_r_mem_8_empty = empty_q;
    assign user_r_mem_8_eof   = eof_q;
    assign fab_data           = fab_data_q;

    // Debug visibility of the read FSM, the pointers and the stream opens
    assign dbg_rd_state = rd_state;
    assign dbg_wp       = wp;
    assign dbg_rp       = rp;
    assign dbg_open     = {user_r_mem_8_open, user_w_mem_8_open};

endmodule

// File: tb/tb_xillybus_mem8_responder.sv
// Bench for xillybus_mem8_responder. Two instances share all inputs:
// instance 0 has EOF_ON_WRAP=0 and instance 1 has EOF_ON_WRAP=1.
module tb_xillybus_mem8_responder;

    // ---------------- clock / reset / stimulus signals ----------------
    logic bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    logic       trn_reset_n;
    logic       quiesce;
    logic       wren;
    logic [7:0] wdata;
    logic       w_open;
    logic       rden;
    logic       r_open;
    logic [4:0] addr;
    logic       upd;
    logic [4:0] fab_addr;

    logic [1:0] full_o;
    logic [1:0] empty_o;
    logic [1:0] eof_o;
    logic [7:0] data_o [2];
    logic [7:0] fab_o [2];
    logic [1:0] st_o [2];
    logic [4:0] wp_o [2];
    logic [4:0] rp_o [2];
    logic [1:0] open_o [2];

    xillybus_mem8_responder #(.EOF_ON_WRAP(1'b0)) u_dut0 (
        .bus_clk(bus_clk), .trn_reset_n(trn_reset_n), .quiesce(quiesce),
        .user_w_mem_8_wren(wren), .user_w_mem_8_data(wdata),
        .user_w_mem_8_full(full_o[0]), .user_w_mem_8_open(w_open),
        .user_r_mem_8_rden(rden), .user_r_mem_8_data(data_o[0]),
        .user_r_mem_8_empty(empty_o[0]), .user_r_mem_8_eof(eof_o[0]),
        .user_r_mem_8_open(r_open), .user_mem_8_addr(addr),
        .user_mem_8_addr_update(upd), .fab_addr(fab_addr), .fab_data(fab_o[0]),
        .dbg_rd_state(st_o[0]), .dbg_wp(wp_o[0]), .dbg_rp(rp_o[0]),
        .dbg_open(open_o[0])
    );

    xillybus_mem8_responder #(.EOF_ON_WRAP(1'b1)) u_dut1 (
        .bus_clk(bus_clk), .trn_reset_n(trn_reset_n), .quiesce(quiesce),
        .user_w_mem_8_wren(wren), .user_w_mem_8_data(wdata),
        .user_w_mem_8_full(full_o[1]), .user_w_mem_8_open(w_open),
        .user_r_mem_8_rden(rden), .user_r_mem_8_data(data_o[1]),
        .user_r_mem_8_empty(empty_o[1]), .user_r_mem_8_eof(eof_o[1]),
        .user_r_mem_8_open(r_open), .user_mem_8_addr(addr),
        .user_mem_8_addr_update(upd), .fab_addr(fab_addr), .fab_data(fab_o[1]),
        .dbg_rd_state(st_o[1]), .dbg_wp(wp_o[1]), .dbg_rp(rp_o[1]),
        .dbg_open(open_o[1])
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    // The stream is modelled as a mode (which bytes the host may take) plus
    // a byte array and two integer cursors.
    localparam int MODE_CLOSED = 0;
    localparam int MODE_SEEK   = 1;
    localparam int MODE_READY  = 2;
    localparam int MODE_DONE   = 3;

    logic [7:0] m_mem [2][32];
    int         m_wp [2];
    int         m_rp [2];
    int         m_mode [2];
    logic [7:0] m_data [2];
    logic [7:0] m_fab [2];
    logic       m_full [2];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit do_wr;
            bit do_rd;
            int old_rp;
            logic [7:0] got;
            if (!trn_reset_n) begin
                for (int a = 0; a < 32; a++) m_mem[i][a] = 8'h00;
                m_wp[i] = 0; m_rp[i] = 0; m_mode[i] = MODE_CLOSED;
                m_data[i] = 8'h00; m_fab[i] = 8'h00; m_full[i] = 1'b1;
                if (i == 0) exp_q0.delete(); else exp_q1.delete();
            end else begin
                do_wr  = wren && !upd && !quiesce && !m_full[i];
                do_rd  = rden && (m_mode[i] == MODE_READY) && !upd && !quiesce;
                old_rp = m_rp[i];
                m_fab[i] = m_mem[i][fab_addr];
                if (do_rd) begin
                    got = (do_wr && m_rp[i] == m_wp[i]) ? wdata : m_mem[i][m_rp[i]];
                    m_data[i] = got;
                    if (i == 0) exp_q0.push_back(got); else exp_q1.push_back(got);
                end
                if (do_wr) m_mem[i][m_wp[i]] = wdata;
                if (upd) begin
                    m_wp[i] = int'(addr);
                    m_rp[i] = int'(addr);
                end else begin
                    if (do_wr) m_wp[i] = (m_wp[i] + 1) % 32;
                    if (do_rd) m_rp[i] = (m_rp[i] + 1) % 32;
                end
                if (!r_open || quiesce)      m_mode[i] = MODE_CLOSED;
                else if (upd)                m_mode[i] = MODE_SEEK;
                else if (m_mode[i] == MODE_CLOSED || m_mode[i] == MODE_SEEK)
                    m_mode[i] = MODE_READY;
                else if (m_mode[i] == MODE_READY && do_rd && old_rp == 31 && i == 1)
                    m_mode[i] = MODE_DONE;
                m_full[i] = quiesce;
            end
        end
    endtask

    task automatic model_check();
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("full[%0d]", i), 32'(full_o[i]), 32'(m_full[i]));
            check($sformatf("empty[%0d]", i), 32'(empty_o[i]), 32'(m_mode[i] != MODE_READY));
            check($sformatf("eof[%0d]", i), 32'(eof_o[i]), 32'(m_mode[i] == MODE_DONE));
            check($sformatf("data[%0d]", i), 32'(data_o[i]), 32'(m_data[i]));
            check($sformatf("fab[%0d]", i), 32'(fab_o[i]), 32'(m_fab[i]));
            check($sformatf("wp[%0d]", i), 32'(wp_o[i]), 32'(m_wp[i]));
            check($sformatf("rp[%0d]", i), 32'(rp_o[i]), 32'(m_rp[i]));
        end
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("rd_byte[0]", 32'(data_o[0]), 32'(e));
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("rd_byte[1]", 32'(data_o[1]), 32'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change just after the falling edge; outputs are sampled there.
    task automatic tick();
        @(posedge bus_clk);
        model_step();
        @(negedge bus_clk);
        model_check();
    endtask

    task automatic drive(bit u, logic [4:0] a, bit w, logic [7:0] d, bit r, logic [4:0] f);
        upd = u; addr = a; wren = w; wdata = d; rden = r; fab_addr = f;
        tick();
    endtask

    task automatic idle(logic [4:0] f);
        drive(1'b0, 5'd0, 1'b0, 8'h00, 1'b0, f);
    endtask

    // ---------------- directed vector table (instance 0) ----------------
    typedef struct {
        bit         upd;
        logic [4:0] addr;
        bit         wren;
        logic [7:0] wdata;
        bit         rden;
        logic [4:0] fab;
        bit         e_empty;
        logic [7:0] e_data;
        logic [7:0] e_fab;
        logic [4:0] e_wp;
        logic [4:0] e_rp;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(bit u, logic [4:0] a, bit w, logic [7:0] d, bit r,
                                logic [4:0] f, bit ee, logic [7:0] ed,
                                logic [7:0] ef, logic [4:0] ew, logic [4:0] er);
        vec_t v;
        v.upd = u; v.addr = a; v.wren = w; v.wdata = d; v.rden = r; v.fab = f;
        v.e_empty = ee; v.e_data = ed; v.e_fab = ef; v.e_wp = ew; v.e_rp = er;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        //            upd addr wr data  rd fab  empty data  fab   wp  rp
        tbl[0]  = mk(1, 5,  0, 8'h00, 0, 0,  1, 8'h00, 8'h00, 5,  5);
        tbl[1]  = mk(0, 0,  1, 8'hA1, 0, 5,  0, 8'h00, 8'h00, 6,  5);
        tbl[2]  = mk(0, 0,  1, 8'hB2, 0, 5,  0, 8'h00, 8'hA1, 7,  5);
        tbl[3]  = mk(0, 0,  1, 8'hC3, 0, 6,  0, 8'h00, 8'hB2, 8,  5);
        tbl[4]  = mk(1, 5,  0, 8'h00, 0, 7,  1, 8'h00, 8'hC3, 5,  5);
        tbl[5]  = mk(0, 0,  0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 5,  5);
        tbl[6]  = mk(0, 0,  0, 8'h00, 1, 0,  0, 8'hA1, 8'h00, 5,  6);
        tbl[7]  = mk(0, 0,  0, 8'h00, 1, 0,  0, 8'hB2, 8'h00, 5,  7);
        tbl[8]  = mk(0, 0,  0, 8'h00, 1, 0,  0, 8'hC3, 8'h00, 5,  8);
        tbl[9]  = mk(1, 30, 0, 8'h00, 0, 0,  1, 8'hC3, 8'h00, 30, 30);
        tbl[10] = mk(0, 0,  1, 8'h10, 0, 0,  0, 8'hC3, 8'h00, 31, 30);
        tbl[11] = mk(0, 0,  1, 8'h11, 0, 0,  0, 8'hC3, 8'h00, 0,  30);
        tbl[12] = mk(0, 0,  1, 8'h12, 0, 0,  0, 8'hC3, 8'h00, 1,  30);
        tbl[13] = mk(0, 0,  1, 8'h13, 0, 30, 0, 8'hC3, 8'h10, 2,  30);
        tbl[14] = mk(0, 0,  0, 8'h00, 0, 31, 0, 8'hC3, 8'h11, 2,  30);
        tbl[15] = mk(0, 0,  0, 8'h00, 0, 0,  0, 8'hC3, 8'h12, 2,  30);
        tbl[16] = mk(0, 0,  0, 8'h00, 0, 1,  0, 8'hC3, 8'h13, 2,  30);
        tbl[17] = mk(0, 0,  0, 8'h00, 1, 2,  0, 8'h10, 8'h00, 2,  31);
        tbl[18] = mk(0, 0,  0, 8'h00, 1, 2,  0, 8'h11, 8'h00, 2,  0);
        tbl[19] = mk(0, 0,  0, 8'h00, 1, 2,  0, 8'h12, 8'h00, 2,  1);

        // reset block
        trn_reset_n = 1'b0; quiesce = 1'b0; w_open = 1'b1; r_open = 1'b1;
        upd = 1'b0; addr = 5'd0; wren = 1'b0; wdata = 8'h00; rden = 1'b0;
        fab_addr = 5'd0;
        tick();
        tick();
        check("rst_full", 32'(full_o[0]), 32'd1);
        check("rst_empty", 32'(empty_o[0]), 32'd1);
        check("rst_eof", 32'(eof_o[0]), 32'd0);
        check("rst_data", 32'(data_o[0]), 32'h00);
        check("rst_fab", 32'(fab_o[0]), 32'h00);

        // first released edge: stream opens, backpressure drops
        trn_reset_n = 1'b1;
        idle(5'd0);
        check("rel_empty", 32'(empty_o[0]), 32'd0);
        check("rel_full", 32'(full_o[0]), 32'd0);

        // table: seek/write/read, wrapped writes, wrapped reads without eof
        for (int k = 0; k < 20; k++) begin
            drive(tbl[k].upd, tbl[k].addr, tbl[k].wren, tbl[k].wdata, tbl[k].rden, tbl[k].fab);
            check($sformatf("tbl%0d_empty", k), 32'(empty_o[0]), 32'(tbl[k].e_empty));
            check($sformatf("tbl%0d_data", k), 32'(data_o[0]), 32'(tbl[k].e_data));
            check($sformatf("tbl%0d_fab", k), 32'(fab_o[0]), 32'(tbl[k].e_fab));
            check($sformatf("tbl%0d_wp", k), 32'(wp_o[0]), 32'(tbl[k].e_wp));
            check($sformatf("tbl%0d_rp", k), 32'(rp_o[0]), 32'(tbl[k].e_rp));
        end
        // instance 1 hit eof when reading address 31, then ignored the next rden
        check("eofwrap_eof1", 32'(eof_o[1]), 32'd1);
        check("eofwrap_empty1", 32'(empty_o[1]), 32'd1);
        check("eofwrap_data1", 32'(data_o[1]), 32'h11);
        check("eofwrap_rp1", 32'(rp_o[1]), 32'd0);

        // eof at address 31, ignored rden, seek back out of DONE
        drive(1'b1, 5'd31, 1'b0, 8'h00, 1'b0, 5'd0);
        check("seek31_empty1", 32'(empty_o[1]), 32'd1);
        check("seek31_eof1", 32'(eof_o[1]), 32'd0);
        idle(5'd0);
        check("seek31_ready1", 32'(empty_o[1]), 32'd0);
        drive(1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 5'd0);
        check("rd31_data1", 32'(data_o[1]), 32'h11);
        check("rd31_empty1", 32'(empty_o[1]), 32'd1);
        check("rd31_eof1", 32'(eof_o[1]), 32'd1);
        check("rd31_rp1", 32'(rp_o[1]), 32'd0);
        check("rd31_empty0", 32'(empty_o[0]), 32'd0);
        drive(1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 5'd0);
        check("done_hold_data1", 32'(data_o[1]), 32'h11);
        check("done_hold_rp1", 32'(rp_o[1]), 32'd0);
        drive(1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 5'd0);
        check("seek0_empty1", 32'(empty_o[1]), 32'd1);
        check("seek0_eof1", 32'(eof_o[1]), 32'd0);
        idle(5'd0);
        check("seek0_ready1", 32'(empty_o[1]), 32'd0);
        check("seek0_noeof1", 32'(eof_o[1]), 32'd0);

        // write-through bypass and fabric port without bypass
        drive(1'b1, 5'd7, 1'b0, 8'h00, 1'b0, 5'd0);
        idle(5'd0);
        drive(1'b0, 5'd0, 1'b1, 8'h5A, 1'b1, 5'd7);
        check("bypass_data0", 32'(data_o[0]), 32'h5A);
        check("bypass_data1", 32'(data_o[1]), 32'h5A);
        check("fab_prewrite", 32'(fab_o[0]), 32'hC3);
        idle(5'd7);
        check("fab_postwrite", 32'(fab_o[0]), 32'h5A);

        // quiesce mid-stream, then a one-cycle reset
        drive(1'b0, 5'd0, 1'b1, 8'h77, 1'b0, 5'd0);
        quiesce = 1'b1;
        drive(1'b0, 5'd0, 1'b1, 8'h99, 1'b1, 5'd0);
        check("q_full", 32'(full_o[0]), 32'd1);
        check("q_empty", 32'(empty_o[0]), 32'd1);
        check("q_wp", 32'(wp_o[0]), 32'd9);
        check("q_rp", 32'(rp_o[0]), 32'd8);
        check("q_data", 32'(data_o[0]), 32'h5A);
        drive(1'b0, 5'd0, 1'b1, 8'hEE, 1'b0, 5'd0);
        check("q_wp_hold", 32'(wp_o[0]), 32'd9);
        quiesce = 1'b0;
        idle(5'd9);
        check("q_dropped", 32'(fab_o[0]), 32'h00);
        trn_reset_n = 1'b0;
        drive(1'b0, 5'd0, 1'b1, 8'h44, 1'b1, 5'd8);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("r2_full%0d", i), 32'(full_o[i]), 32'd1);
            check($sformatf("r2_empty%0d", i), 32'(empty_o[i]), 32'd1);
            check($sformatf("r2_eof%0d", i), 32'(eof_o[i]), 32'd0);
            check($sformatf("r2_data%0d", i), 32'(data_o[i]), 32'h00);
            check($sformatf("r2_fab%0d", i), 32'(fab_o[i]), 32'h00);
            check($sformatf("r2_wp%0d", i), 32'(wp_o[i]), 32'd0);
            check($sformatf("r2_rp%0d", i), 32'(rp_o[i]), 32'd0);
        end
        trn_reset_n = 1'b1;
        idle(5'd7);
        check("r2_mem_cleared", 32'(fab_o[0]), 32'h00);

        // randomized phase against the reference model
        for (int n = 0; n < 4000; n++) begin
            trn_reset_n = (32'($urandom_range(0, 299)) != 0);
            quiesce     = (32'($urandom_range(0, 49)) == 0);
            r_open      = (32'($urandom_range(0, 59)) != 0);
            w_open      = (32'($urandom_range(0, 9)) != 0);
            drive(32'($urandom_range(0, 15)) == 0, 5'($urandom_range(0, 31)),
                  32'($urandom_range(0, 1)) == 1, 8'($urandom_range(0, 255)),
                  32'($urandom_range(0, 2)) != 0, 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xillybus_mem8_responder.md
XILLYBUS_MEM8_RESPONDER -- requirements
Module: xillybus_mem8_responder

Interface
REQ-001 Parameter EOF_ON_WRAP, default 0: when 1, reading address 31 ends the stream with eof.
REQ-002 Port bus_clk  in  1  single clock; all logic on its rising edge.
REQ-003 Port trn_reset_n  in  1  reset, synchronous and active-low.
REQ-004 Port quiesce  in  1  core quiesced; host side inactive.
REQ-005 Port user_w_mem_8_wren  in  1  host write strobe.
REQ-006 Port user_w_mem_8_data  in  8  host write byte.
REQ-007 Port user_w_mem_8_full  out  1  write backpressure.
REQ-008 Port user_w_mem_8_open  in  1  write stream open.
REQ-009 Port user_r_mem_8_rden  in  1  host read strobe.
REQ-010 Port user_r_mem_8_data  out  8  read byte.
REQ-011 Port user_r_mem_8_empty  out  1  no byte available.
REQ-012 Port user_r_mem_8_eof  out  1  end of stream.
REQ-013 Port user_r_mem_8_open  in  1  read stream open.
REQ-014 Port user_mem_8_addr  in  5  seek address.
REQ-015 Port user_mem_8_addr_update  in  1  seek strobe.
REQ-016 Port fab_addr  in  5  fabric-side read address.
REQ-017 Port fab_data  out  8  fabric-side read data, registered.

Function
REQ-018 Storage SHALL be 32x8 registers, plus a 5-bit write pointer wp and a 5-bit read pointer rp.
REQ-019 Pointers SHALL increment modulo 32, so 31+1=0.
REQ-020 On a cycle with addr_update=1, wp and rp SHALL both load user_mem_8_addr; any wren or rden in that cycle SHALL be ignored.
REQ-021 A write SHALL occur when wren=1, addr_update=0, quiesce=0 and full=0: mem[wp]<=data, wp<=wp+1.
REQ-022 full SHALL be registered: 1 during reset and while quiesce=1, 0 otherwise, with one-cycle lag.
REQ-023 The read side SHALL be an FSM with four states.
  - CLOSED: empty=1, eof=0.
  - SEEK: empty=1, eof=0.
  - READY: empty=0, eof=0.
  - DONE: empty=1, eof=1.
REQ-024 FSM transitions:
  - Any state with read open=0 or quiesce=1 goes to CLOSED.
  - Else addr_update=1 goes to SEEK.
  - CLOSED with open=1 goes to READY.
  - SEEK goes to READY after one cycle.
  - READY goes to DONE on an accepted rden with rp==31, when EOF_ON_WRAP=1.
  - DONE is left only via addr_update or close.
REQ-025 empty and eof SHALL be registered FSM decodes.
REQ-026 An accepted read (rden=1 while empty=0) SHALL set data<=mem[rp] and rp<=rp+1.
REQ-027 Read data SHALL be valid on the cycle after rden and hold until the next accepted read.
REQ-028 rden while empty=1 SHALL be ignored: no pointer change, data held.
REQ-029 Simultaneous accepted read and write with rp==wp SHALL return the newly written byte (write-through bypass).
REQ-030 Closing a stream SHALL NOT alter rp, wp or memory contents.
REQ-031 fab_data SHALL be mem[fab_addr] one cycle later, pre-write value on a same-cycle write (no bypass).
REQ-032 With EOF_ON_WRAP=0, rp SHALL wrap 31 to 0 and READY SHALL persist.

Reset
REQ-033 While trn_reset_n=0, the block SHALL apply all of the following:
  - memory, wp, rp, user_r_mem_8_data and fab_data cleared to 0;
  - FSM set to CLOSED (empty=1, eof=0);
  - full=1.
REQ-034 Reset asserted mid-operation SHALL override every other input in that cycle.
REQ-035 After release, the FSM SHALL enter READY no earlier than one cycle later, when read open=1.

Verification
REQ-036 Seek 5, write 0xA1,0xB2,0xC3; seek 5; read 3 -> data 0xA1,0xB2,0xC3, each one cycle after its rden; rp=8.
REQ-037 Seek 30, write 4 bytes 0x10..0x13 -> mem[30]=0x10, mem[31]=0x11, mem[0]=0x12, mem[1]=0x13; wp=2.
REQ-038 EOF_ON_WRAP=1: seek 31, rden -> data=mem[31]; next cycle empty=1, eof=1; further rden is ignored; seek 0 -> one SEEK cycle, then empty=0, eof=0.
REQ-039 Seek 7, then wren 0x5A with rden in the same cycle -> read data=0x5A, mem[7]=0x5A; fab_addr=7 in the write cycle returns the old value, the next cycle returns 0x5A.
REQ-040 quiesce=1 mid-stream -> full=1 and empty=1 next cycle, writes dropped, pointers unchanged; trn_reset_n=0 for one cycle -> all outputs at their REQ-033 reset values.
